// File: rtl/ysyx_25040109_lsu_pkg.sv
// rtl/ysyx_25040109_lsu_pkg.sv - LSU encodings, FSM state codes and request record
package ysyx_25040109_lsu_pkg;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] WLEN_B = 3'b001;
    localparam logic [2:0] WLEN_H = 3'b010;
    localparam logic [2:0] WLEN_W = 3'b100;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LREQ  = 3'd1;
    localparam logic [2:0] ST_LWAIT = 3'd2;
    localparam logic [2:0] ST_STORE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic [4:0]  rd;
    } req_t;

    // Store byte count from the size bits of funct3 (sign bit is irrelevant for stores).
    function automatic logic [2:0] wlen_of(input logic [1:0] size);
        case (size)
            2'b00:   wlen_of = WLEN_B;
            2'b01:   wlen_of = WLEN_H;
            default: wlen_of = WLEN_W;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_if.sv
// rtl/ysyx_25040109_lsu_if.sv - EXU request, WBU result and data-memory channels of the LSU
interface ysyx_25040109_lsu_if;
    import ysyx_25040109_lsu_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_wen;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_wdata;
    logic        out_err;

    logic [31:0] dmem_raddr;
    logic        dmem_rvalid;
    logic        dmem_rready;
    logic [31:0] dmem_rdata;
    logic        dmem_rdata_valid;
    logic        dmem_rdata_ready;

    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [2:0]  dmem_wlen;
    logic        dmem_wvalid;
    logic        dmem_wready;

    modport slave (
        input  in_valid, in_op, in_funct3, in_addr, in_wdata, in_result, in_rd, in_wen,
        output in_ready,
        input  out_ready,
        output out_valid, out_rd, out_wen, out_wdata, out_err,
        input  dmem_rready, dmem_rdata, dmem_rdata_valid,
        output dmem_raddr, dmem_rvalid, dmem_rdata_ready,
        input  dmem_wready,
        output dmem_waddr, dmem_wdata, dmem_wlen, dmem_wvalid
    );

    modport master (
        output in_valid, in_op, in_funct3, in_addr, in_wdata, in_result, in_rd, in_wen,
        input  in_ready,
        output out_ready,
        input  out_valid, out_rd, out_wen, out_wdata, out_err,
        output dmem_rready, dmem_rdata, dmem_rdata_valid,
        input  dmem_raddr, dmem_rvalid, dmem_rdata_ready,
        output dmem_wready,
        input  dmem_waddr, dmem_wdata, dmem_wlen, dmem_wvalid
    );

endinterface

// File: rtl/ysyx_25040109_lsu_align.sv
// rtl/ysyx_25040109_lsu_align.sv - load lane select/extend and access legality check
module ysyx_25040109_lsu_align
    import ysyx_25040109_lsu_pkg::*;
(
    input  logic [1:0]  chk_op,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_offset,
    output logic        chk_err,
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        chk_err = 1'b0;
        case (chk_op)
            OP_LOAD:  chk_err = !(chk_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
            OP_STORE: chk_err = !(chk_funct3 inside {F3_B, F3_H, F3_W});
            OP_ILL:   chk_err = 1'b1;
            default:  chk_err = 1'b0;
        endcase
        // Size bits are shared by signed and unsigned variants, so HU misalignment is caught too.
        if (chk_op == OP_LOAD || chk_op == OP_STORE) begin
            if (chk_funct3[1:0] == 2'b01 && chk_offset[0])
                chk_err = 1'b1;
            if (chk_funct3[1:0] == 2'b10 && chk_offset != 2'b00)
                chk_err = 1'b1;
        end
    end

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// rtl/ysyx_25040109_lsu.sv - single-outstanding load/store unit between EXU and WBU
module ysyx_25040109_lsu
    import ysyx_25040109_lsu_pkg::*;
(
    input logic               clk,
    input logic               rst,
    ysyx_25040109_lsu_if.slave lsu
);

    logic [2:0]  state;
    req_t        req;
    logic [31:0] res_wdata;
    logic        res_wen;
    logic        res_err;
    logic        chk_err;
    logic [31:0] ld_data;

    ysyx_25040109_lsu_align u_align (
        .chk_op     (lsu.in_op),
        .chk_funct3 (lsu.in_funct3),
        .chk_offset (lsu.in_addr[1:0]),
        .chk_err    (chk_err),
        .word       (lsu.dmem_rdata),
        .offset     (req.addr[1:0]),
        .funct3     (req.funct3),
        .data       (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req       <= '0;
            res_wdata <= '0;
            res_wen   <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu.in_valid) begin
                        req       <= '{addr: lsu.in_addr, wdata: lsu.in_wdata,
                                       funct3: lsu.in_funct3, rd: lsu.in_rd};
                        res_wdata <= '0;
                        res_wen   <= 1'b0;
                        res_err   <= chk_err;
                        if (chk_err) begin
                            state <= ST_RESP;
                        end else begin
                            case (lsu.in_op)
                                OP_LOAD:  state <= ST_LREQ;
                                OP_STORE: state <= ST_STORE;
                                default: begin
                                    res_wdata <= lsu.in_result;
                                    res_wen   <= lsu.in_wen;
                                    state     <= ST_RESP;
                                end
                            endcase
                        end
                    end
                end
                ST_LREQ: begin
                    if (lsu.dmem_rready)
                        state <= ST_LWAIT;
                end
                ST_LWAIT: begin
                    if (lsu.dmem_rdata_valid) begin
                        res_wdata <= ld_data;
                        res_wen   <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_STORE: begin
                    if (lsu.dmem_wready)
                        state <= ST_RESP;
                end
                ST_RESP: begin
                    if (lsu.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All request fields come from the latched record, so they stay stable while valid is up.
    assign lsu.in_ready         = (state == ST_IDLE);
    assign lsu.out_valid        = (state == ST_RESP);
    assign lsu.out_rd           = req.rd;
    assign lsu.out_wen          = res_wen;
    assign lsu.out_wdata        = res_wdata;
    assign lsu.out_err          = res_err;

    assign lsu.dmem_raddr       = {req.addr[31:2], 2'b00};
    assign lsu.dmem_rvalid      = (state == ST_LREQ);
    assign lsu.dmem_rdata_ready = (state == ST_LWAIT);

    assign lsu.dmem_waddr       = req.addr;
    assign lsu.dmem_wdata       = req.wdata;
    assign lsu.dmem_wlen        = (state == ST_STORE) ? wlen_of(req.funct3[1:0]) : 3'b000;
    assign lsu.dmem_wvalid      = (state == ST_STORE);

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// tb/tb_ysyx_25040109_lsu.sv - directed scoreboard bench for the LSU
module tb_ysyx_25040109_lsu;
    import ysyx_25040109_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_25040109_lsu_if bus ();

    ysyx_25040109_lsu dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic        err;
        logic [31:0] wdata;
        logic        chk_data;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
    } st_t;

    exp_t        res_q[$];
    logic [31:0] rd_addr_q[$];
    st_t         st_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fire_cyc = 0;
    int rcnt = 0;
    int wcnt = 0;
    logic seen = 1'b0;
    logic [31:0] mem_word = 32'h0;
    logic rd_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: rready idle-high, read data one cycle after the request is taken.
    always @(posedge clk) begin
        if (rst) begin
            rd_pend               <= 1'b0;
            bus.dmem_rdata_valid  <= 1'b0;
            bus.dmem_rdata        <= 32'h0;
        end else begin
            rd_pend               <= bus.dmem_rvalid && bus.dmem_rready;
            bus.dmem_rdata_valid  <= rd_pend;
            bus.dmem_rdata        <= rd_pend ? mem_word : 32'h0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        st_t  s;
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready)
                fire_cyc = cyc;
            if (bus.dmem_rvalid && bus.dmem_rready) begin
                rcnt++;
                check("read_expected", {31'h0, rd_addr_q.size() != 0}, 32'h1);
                if (rd_addr_q.size() != 0)
                    check("dmem_raddr", bus.dmem_raddr, rd_addr_q.pop_front());
            end
            if (bus.dmem_wvalid && bus.dmem_wready) begin
                wcnt++;
                check("store_expected", {31'h0, st_q.size() != 0}, 32'h1);
                if (st_q.size() != 0) begin
                    s = st_q.pop_front();
                    check("dmem_waddr", bus.dmem_waddr, s.addr);
                    check("dmem_wdata", bus.dmem_wdata, s.data);
                    check("dmem_wlen", {29'h0, bus.dmem_wlen}, {29'h0, s.len});
                end
            end
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                check("result_expected", {31'h0, res_q.size() != 0}, 32'h1);
                if (res_q.size() != 0)
                    check("latency", cyc - fire_cyc, res_q[0].lat);
            end
            if (bus.out_valid && bus.out_ready) begin
                seen = 1'b0;
                if (res_q.size() != 0) begin
                    e = res_q.pop_front();
                    check("out_rd", {27'h0, bus.out_rd}, {27'h0, e.rd});
                    check("out_wen", {31'h0, bus.out_wen}, {31'h0, e.wen});
                    check("out_err", {31'h0, bus.out_err}, {31'h0, e.err});
                    if (e.chk_data)
                        check("out_wdata", bus.out_wdata, e.wdata);
                end
            end
        end
    end

    task automatic reset_checks(input string p);
        check({p, "_in_ready"}, {31'h0, bus.in_ready}, 32'h1);
        check({p, "_out_valid"}, {31'h0, bus.out_valid}, 32'h0);
        check({p, "_out_wen"}, {31'h0, bus.out_wen}, 32'h0);
        check({p, "_out_err"}, {31'h0, bus.out_err}, 32'h0);
        check({p, "_rvalid"}, {31'h0, bus.dmem_rvalid}, 32'h0);
        check({p, "_wvalid"}, {31'h0, bus.dmem_wvalid}, 32'h0);
        check({p, "_rdata_ready"}, {31'h0, bus.dmem_rdata_ready}, 32'h0);
        check({p, "_out_rd"}, {27'h0, bus.out_rd}, 32'h0);
        check({p, "_out_wdata"}, bus.out_wdata, 32'h0);
        check({p, "_raddr"}, bus.dmem_raddr, 32'h0);
        check({p, "_waddr"}, bus.dmem_waddr, 32'h0);
        check({p, "_wdata"}, bus.dmem_wdata, 32'h0);
        check({p, "_wlen"}, {29'h0, bus.dmem_wlen}, 32'h0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] result,
                         input logic [4:0] rd, input logic wen);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_issue", {31'h0, bus.in_ready}, 32'h1);
        bus.in_op     = op;
        bus.in_funct3 = f3;
        bus.in_addr   = addr;
        bus.in_wdata  = wd;
        bus.in_result = result;
        bus.in_rd     = rd;
        bus.in_wen    = wen;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((res_q.size() != 0 || rd_addr_q.size() != 0 || st_q.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", res_q.size() + rd_addr_q.size() + st_q.size(), 32'h0);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                        input logic [4:0] rd, input logic [31:0] exp_data);
        logic [31:0] a;
        a = addr;
        mem_word = word;
        rd_addr_q.push_back({a[31:2], 2'b00});
        res_q.push_back('{rd: rd, wen: 1'b1, err: 1'b0, wdata: exp_data, chk_data: 1'b1, lat: 4});
        issue(OP_LOAD, f3, addr, 32'h0, 32'h0, rd, 1'b0);
        drain();
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [2:0] len);
        int w0;
        w0 = wcnt;
        st_q.push_back('{addr: addr, data: wd, len: len});
        res_q.push_back('{rd: rd, wen: 1'b0, err: 1'b0, wdata: 32'h0, chk_data: 1'b0, lat: 2});
        issue(OP_STORE, f3, addr, wd, 32'h0, rd, 1'b1);
        drain();
        check("store_wvalid_cycles", wcnt - w0, 32'h1);
    endtask

    task automatic bad(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [4:0] rd);
        res_q.push_back('{rd: rd, wen: 1'b0, err: 1'b1, wdata: 32'h0, chk_data: 1'b1, lat: 1});
        issue(op, f3, addr, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        bus.in_valid    = 1'b0;
        bus.in_op       = 2'b00;
        bus.in_funct3   = 3'b000;
        bus.in_addr     = 32'h0;
        bus.in_wdata    = 32'h0;
        bus.in_result   = 32'h0;
        bus.in_rd       = 5'd0;
        bus.in_wen      = 1'b0;
        bus.out_ready   = 1'b1;
        bus.dmem_rready = 1'b1;
        bus.dmem_wready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        load(F3_W,  32'h8000_0004, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF);
        load(F3_B,  32'h8000_0003, 32'h80FF_7F01, 5'd6, 32'hFFFF_FF80);
        load(F3_BU, 32'h8000_0003, 32'h80FF_7F01, 5'd6, 32'h0000_0080);
        load(F3_H,  32'h8000_0002, 32'h80FF_7F01, 5'd8, 32'hFFFF_80FF);
        load(F3_HU, 32'h8000_0002, 32'h80FF_7F01, 5'd8, 32'h0000_80FF);
        load(F3_B,  32'h8000_0001, 32'h80FF_7F01, 5'd0, 32'h0000_007F);
        load(F3_H,  32'h8000_0000, 32'h80FF_7F01, 5'd1, 32'h0000_7F01);

        store(F3_H, 32'h8000_0102, 32'h1234_5678, 5'd9,  WLEN_H);
        store(F3_B, 32'h8000_0103, 32'hAABB_CCDD, 5'd10, WLEN_B);
        store(F3_W, 32'h8000_0100, 32'h0BAD_F00D, 5'd11, WLEN_W);

        r0 = rcnt;
        w0 = wcnt;
        bad(OP_LOAD,  F3_W,   32'h8000_0002, 5'd12);
        bad(OP_STORE, F3_H,   32'h8000_0001, 5'd13);
        bad(OP_ILL,   F3_W,   32'h8000_0000, 5'd14);
        bad(OP_LOAD,  3'b011, 32'h8000_0000, 5'd15);
        bad(OP_STORE, 3'b100, 32'h8000_0000, 5'd16);
        bad(OP_LOAD,  F3_HU,  32'h8000_0003, 5'd17);
        check("err_no_read", rcnt - r0, 32'h0);
        check("err_no_write", wcnt - w0, 32'h0);

        bus.out_ready = 1'b0;
        res_q.push_back('{rd: 5'd7, wen: 1'b1, err: 1'b0, wdata: 32'h55, chk_data: 1'b1, lat: 1});
        issue(OP_NONE, F3_B, 32'h0, 32'h0, 32'h55, 5'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
            check("hold_out_wdata", bus.out_wdata, 32'h55);
            check("hold_out_rd", {27'h0, bus.out_rd}, 32'h7);
            check("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("none_idle_after_fire", {31'h0, bus.in_ready}, 32'h1);
        check("none_popped", res_q.size(), 32'h0);

        res_q.push_back('{rd: 5'd2, wen: 1'b0, err: 1'b0, wdata: 32'h1234, chk_data: 1'b1, lat: 1});
        issue(OP_NONE, F3_W, 32'h0, 32'h0, 32'h1234, 5'd2, 1'b0);
        drain();

        mem_word = 32'h1111_1111;
        rd_addr_q.push_back(32'h8000_0008);
        issue(OP_LOAD, F3_W, 32'h8000_0008, 32'h0, 32'h0, 5'd3, 1'b0);
        @(posedge clk); #1;
        check("abort_in_lwait", {31'h0, bus.dmem_rdata_ready}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        reset_checks("abort");
        rst = 1'b0;
        check("abort_no_pending_read", rd_addr_q.size(), 32'h0);

        load(F3_W, 32'h8000_000C, 32'hCAFE_F00D, 5'd4, 32'hCAFE_F00D);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
